// File: rtl/alu_pkg.sv
// Shared constants and helpers for the ALU-lane stream demultiplexer.
package alu_pkg;

  // Number of output channels and the width of the select that addresses them
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  // Width of each per-channel delivered-beat counter
  localparam int CNT_W  = 8;

  // Occupancy of a 2-entry channel buffer
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Decode a channel select into a one-hot channel vector
  function automatic logic [NUM_CH-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] oh;
    case (sel)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/chan_fifo2.sv
// One 2-entry channel buffer: head/tail registers, occupancy and a
// wrapping count of beats delivered to the consumer.
module chan_fifo2
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count,
  output occ_e             o_occ
);

  occ_e             r_occ;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  occ_e             w_occ_nxt;
  logic [WIDTH-1:0] w_head_nxt;
  logic [WIDTH-1:0] w_tail_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_pop;

  // A pop happens only when the head is valid and the consumer takes it
  always_comb begin
    w_pop = 1'b0;
    if (r_occ != OCC_EMPTY) begin
      w_pop = i_pop_ready;
    end else begin
      w_pop = 1'b0;
    end
  end

  // Next buffer contents and occupancy for every push/pop combination
  always_comb begin
    w_occ_nxt  = r_occ;
    w_head_nxt = r_head;
    w_tail_nxt = r_tail;
    case ({i_push, w_pop})
      2'b10: begin
        case (r_occ)
          OCC_EMPTY: begin
            w_head_nxt = i_data;
            w_occ_nxt  = OCC_ONE;
          end
          OCC_ONE: begin
            w_tail_nxt = i_data;
            w_occ_nxt  = OCC_FULL;
          end
          default: begin
            // Push into a full buffer is blocked upstream; hold state
            w_occ_nxt = r_occ;
          end
        endcase
      end
      2'b01: begin
        // Tail moves up to the head; clear the vacated slot
        w_head_nxt = r_tail;
        w_tail_nxt = {WIDTH{1'b0}};
        if (r_occ == OCC_FULL) begin
          w_occ_nxt = OCC_ONE;
        end else begin
          w_occ_nxt = OCC_EMPTY;
        end
      end
      2'b11: begin
        // Occupancy unchanged; new beat queues behind whatever remains
        if (r_occ == OCC_FULL) begin
          w_head_nxt = r_tail;
          w_tail_nxt = i_data;
        end else begin
          w_head_nxt = i_data;
        end
      end
      default: begin
        w_occ_nxt = r_occ;
      end
    endcase
  end

  // Delivered-beat counter advances once per output transfer, wrapping at 256
  always_comb begin
    w_count_nxt = r_count;
    if (w_pop) begin
      w_count_nxt = r_count + 8'd1;
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Buffer state register; reset discards any buffered beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ   <= OCC_EMPTY;
      r_head  <= {WIDTH{1'b0}};
      r_tail  <= {WIDTH{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      r_occ   <= w_occ_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign o_valid = (r_occ != OCC_EMPTY);
  assign o_data  = r_head;
  assign o_count = r_count;
  assign o_occ   = r_occ;

endmodule

// File: rtl/stream_demux_1to4.sv
// 1-to-4 stream demultiplexer: routes each input beat to the buffer of the
// channel named by in_sel; each channel drains on its own valid/ready pair.
module stream_demux_1to4
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH*CNT_W-1:0] out_count
);

  occ_e              w_occ [NUM_CH];
  logic              w_in_ready;
  logic [NUM_CH-1:0] w_push_oh;

  // Accept unless the addressed channel is full; a pop in the same cycle
  // does not open space, so out_ready never reaches in_ready
  always_comb begin
    w_in_ready = 1'b0;
    if (w_occ[in_sel] != OCC_FULL) begin
      w_in_ready = 1'b1;
    end else begin
      w_in_ready = 1'b0;
    end
  end

  // One-hot push to the addressed channel on an input transfer
  always_comb begin
    w_push_oh = {NUM_CH{1'b0}};
    if (in_valid && w_in_ready) begin
      w_push_oh = sel_to_onehot(in_sel);
    end else begin
      w_push_oh = {NUM_CH{1'b0}};
    end
  end

  assign in_ready = w_in_ready;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    chan_fifo2 #(
      .WIDTH(WIDTH)
    ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_push     (w_push_oh[k]),
      .i_pop_ready(out_ready[k]),
      .i_data     (in_data),
      .o_valid    (out_valid[k]),
      .o_data     (out_data[k*WIDTH +: WIDTH]),
      .o_count    (out_count[k*CNT_W +: CNT_W]),
      .o_occ      (w_occ[k])
    );
  end

endmodule

// File: doc/stream_demux_1to4.md
# stream_demux_1to4

Sequential 1-to-4 stream demultiplexer: the distributing counterpart of the datapath's 4-to-1 select muxes. One valid/ready input stream carries a 2-bit destination select with each beat. Each beat is routed into one of four 2-entry per-channel buffers, and each buffer drains independently on its own valid/ready output. The block sits in front of the 8-bit ALU lanes and fans operand beats out to per-lane consumers. Each output keeps an 8-bit wrapping count of beats it has delivered.

## Interface
Parameters:
- WIDTH, 8, data width of each beat

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous and active-low; one clock, no other clock domains
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts beat this cycle
- in_data  in  WIDTH  input beat payload
- in_sel  in  2  destination channel 0..3, qualified by in_valid
- out_valid  out  4  bit k: channel k head entry valid
- out_ready  in  4  bit k: consumer k takes head this cycle
- out_data  out  4*WIDTH  channel k data at bits [k*WIDTH +: WIDTH]
- out_count  out  32  channel k delivered-beat count at bits [k*8 +: 8]

## Operation
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer on channel k occurs when out_valid[k] && out_ready[k].
- in_ready = (occupancy of channel in_sel < 2):
  - Combinational from in_sel and registered occupancy only.
  - Never depends on out_ready.
  - in_ready is don't-care while in_valid = 0, but must still follow the same formula.
- Each channel is a 2-entry FIFO with occupancy 0/1/2. Per-cycle update per channel:
  - push only: occupancy +1
  - pop only: occupancy −1
  - push and pop: occupancy unchanged; the new beat queues behind the remaining entry
  - A push when occupancy = 2 is impossible by construction, including when out_ready is high in that cycle: a full channel is not written in the same cycle it is popped.
- Ordering and independence:
  - Beat order is preserved within a channel.
  - Channels are fully independent. A full channel blocks only beats addressed to it, and no beats are dropped.
- out_valid[k] = (occupancy_k != 0). out_data slice k shows the head entry and holds stable while out_valid[k] = 1 and out_ready[k] = 0.
- out_count channel k increments by 1 per output transfer on channel k, modulo 256 (255 → 0).
- in_data / in_sel are ignored while in_valid = 0.

## Timing
- Reset values (async assert, any cycle, including mid-transfer):
  - occupancy 0, out_valid 0, out_data 0, out_count 0, storage 0.
  - Buffered beats are discarded.
  - in_ready follows from occupancy, so it reads 1 during reset.
- Latency: a beat accepted at edge N is visible on out_valid/out_data after edge N (1 cycle). There is no combinational in→out path.
- Throughput: one input beat per cycle. Each channel sustains one beat per cycle with out_ready held high.
- Deassertion of rst_n is synchronized externally. The first transfer is legal on the first edge after release.
- Output data is registered. in_ready is the only output with combinational dependence on an input (in_sel).

## Structure
- Shared package (alu_pkg): channel count constant NUM_CH = 4, select width SEL_W = 2, counter width CNT_W = 8.
- Sub-module: chan_fifo2 — one 2-entry FIFO with push/pop/occupancy, head data and an 8-bit delivered counter. Instantiated 4 times via generate.
- The top level decodes in_sel into a one-hot push vector and builds in_ready.

## Test plan
- Reset then single beat: in_sel = 2, in_data = 0xA5, out_ready = 0 → out_valid = 0100 next cycle, slice 2 = 0xA5. All other outputs stay at reset values.
- Fill and backpressure: three beats 0x11, 0x22, 0x33 to channel 1 with out_ready = 0 → first two accepted, in_ready = 0 on the third. A beat to channel 3 on the next cycle is still accepted.
- Order and simultaneous push/pop: channel 0 holds 0x01. Push 0x02 while popping → occupancy stays 1, head = 0x02 next cycle. out_count[7:0] = 1.
- Full-channel pop does not admit a push: channel 0 is full and out_ready[0] = 1 → in_ready = 0 for in_sel = 0 that cycle. The push succeeds the following cycle.
- Counter wrap: 256 beats streamed through channel 3 with out_ready high → out_count[31:24] returns to 0x00, and no beats are lost (scoreboard).
- Async reset mid-stream: assert rst_n low between edges with all channels holding data → out_valid = 0000 and counts 0 immediately, without waiting for a clock edge.
